// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if: arbitration bus between AHB masters/slaves and the arbiter.
//   slave  modport : arbiter side (samples requests, drives grant/owner).
//   master modport : bus side (drives requests/transfer status, sees grant).
// Signals: hbusreq/hlock/hsplit[15:0], hready, htrans[1:0], hresp[1:0],
//          hgrant[15:0], hmaster[3:0], hmastlock, split_mask[15:0].
interface ahb_arbiter_if;
  logic [15:0] hbusreq;
  logic [15:0] hlock;
  logic [15:0] hsplit;
  logic        hready;
  logic [1:0]  htrans;
  logic [1:0]  hresp;
  logic [15:0] hgrant;
  logic [3:0]  hmaster;
  logic        hmastlock;
  logic [15:0] split_mask;

  modport slave (
    input  hbusreq, hlock, hsplit, hready, htrans, hresp,
    output hgrant, hmaster, hmastlock, split_mask
  );

  modport master (
    output hbusreq, hlock, hsplit, hready, htrans, hresp,
    input  hgrant, hmaster, hmastlock, split_mask
  );
endinterface

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: AHB bus arbiter with round-robin selection, lock hold, burst
// hold, SPLIT masking and a default master.
// Ports:
//   hclk  - bus clock, rising edge
//   hrst  - asynchronous active-high reset
//   bus   - ahb_arbiter_if.slave: hbusreq/hlock/hsplit/hready/htrans/hresp
//           in; hgrant/hmaster/hmastlock/split_mask out (all registered)
// Build option: define AHB_ARB_FIXED_PRIO_EN for fixed priority (lowest
// eligible index wins, no round-robin pointer); default build is round-robin.
module ahb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 16,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic         hclk,
  input  logic         hrst,
  ahb_arbiter_if.slave bus
);

  localparam int unsigned NM_W  = 16;
  localparam int unsigned IDX_W = 4;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  // Bits of the 16-wide vectors that belong to implemented masters.
  localparam logic [NM_W:0]    ACT_FULL   = (17'd1 << NUM_MASTERS) - 17'd1;
  localparam logic [NM_W-1:0]  ACTIVE     = ACT_FULL[NM_W-1:0];
  localparam logic [IDX_W-1:0] DEF_IDX    = IDX_W'(DEFAULT_MASTER);
  localparam logic [NM_W-1:0]  DEF_ONEHOT = NM_W'(1) << DEFAULT_MASTER;

  logic [NM_W-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] mst_q, mst_d;
  logic             lock_q, lock_d;
  logic [NM_W-1:0]  mask_q, mask_d;
  logic             split_pend_q, split_pend_d;
`ifndef AHB_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [31:0]      cand;
`endif

  logic [NM_W-1:0]  busreq, lockv, splitv, set_vec, eligible;
  logic             resp_split, resp_retry;
  logic             hold_lock, hold_lockseq, hold_burst, rearb;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // Request qualification and SPLIT mask set vector for this edge.
  always_comb begin
    busreq     = bus.hbusreq & ACTIVE;
    lockv      = bus.hlock & ACTIVE;
    splitv     = bus.hsplit & ACTIVE;
    resp_split = (bus.hresp == HRESP_SPLIT);
    resp_retry = (bus.hresp == HRESP_RETRY);
    set_vec    = '0;
    if (bus.hready && resp_split && (mst_q != DEF_IDX))
      set_vec = NM_W'(1) << mst_q;
    // A master being split at this edge must not win the same edge.
    eligible = busreq & ~(mask_q | set_vec);
  end

  // Winner selection over the eligible set.
`ifdef AHB_ARB_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = DEF_IDX;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!win_found && eligible[IDX_W'(i)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end
`else
  // Circular search starting just after the last winner; the last candidate
  // is rr_q itself, so a sole requester keeps the bus.
  always_comb begin
    win_found = 1'b0;
    win_idx   = DEF_IDX;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= NUM_MASTERS)
        cand = cand - NUM_MASTERS;
      if (!win_found && eligible[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end
`endif

  // Hold conditions and next-state.
  always_comb begin
    gnt_d        = gnt_q;
    gnt_idx_d    = gnt_idx_q;
    mst_d        = mst_q;
    lock_d       = lock_q;
    split_pend_d = split_pend_q;
`ifndef AHB_ARB_FIXED_PRIO_EN
    rr_d         = rr_q;
`endif

    hold_lock    = lockv[gnt_idx_q] & busreq[gnt_idx_q];
    hold_lockseq = lock_q && (bus.htrans != HTRANS_IDLE);
    hold_burst   = ((bus.htrans == HTRANS_SEQ) || (bus.htrans == HTRANS_BUSY)) &&
                   !(resp_split || resp_retry);
    // A SPLIT seen in its first (wait) cycle overrides every hold.
    rearb        = bus.hready &&
                   (split_pend_q || !(hold_lock || hold_lockseq || hold_burst));

    // Set wins over a same-edge release.
    mask_d = ((mask_q & ~splitv) | set_vec) & ACTIVE;

    if (bus.hready)
      split_pend_d = 1'b0;
    else if (resp_split)
      split_pend_d = 1'b1;

    // Address-phase ownership follows the grant by one hready cycle.
    if (bus.hready) begin
      mst_d  = gnt_idx_q;
      lock_d = lockv[gnt_idx_q];
    end

    if (rearb) begin
      gnt_idx_d = win_idx;
      gnt_d     = NM_W'(1) << win_idx;
`ifndef AHB_ARB_FIXED_PRIO_EN
      if (win_found)
        rr_d = win_idx;
`endif
    end
  end

  // State registers.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      gnt_q        <= DEF_ONEHOT;
      gnt_idx_q    <= DEF_IDX;
      mst_q        <= DEF_IDX;
      lock_q       <= 1'b0;
      mask_q       <= '0;
      split_pend_q <= 1'b0;
`ifndef AHB_ARB_FIXED_PRIO_EN
      rr_q         <= DEF_IDX;
`endif
    end else begin
      gnt_q        <= gnt_d;
      gnt_idx_q    <= gnt_idx_d;
      mst_q        <= mst_d;
      lock_q       <= lock_d;
      mask_q       <= mask_d;
      split_pend_q <= split_pend_d;
`ifndef AHB_ARB_FIXED_PRIO_EN
      rr_q         <= rr_d;
`endif
    end
  end

  assign bus.hgrant     = gnt_q;
  assign bus.hmaster    = mst_q;
  assign bus.hmastlock  = lock_q;
  assign bus.split_mask = mask_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scoreboard bench for ahb_arbiter. The driver
// queues hand-computed expected outputs per cycle; the monitor compares them
// against the DUT after each clock edge and after reset assertion.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE = 2'b00, NS = 2'b10, SEQ = 2'b11;
  localparam logic [1:0] OK = 2'b00, RTY = 2'b10, SPL = 2'b11;
`ifdef AHB_ARB_FIXED_PRIO_EN
  localparam bit FX = 1'b1;
`else
  localparam bit FX = 1'b0;
`endif

  typedef struct {
    logic [15:0] g;
    logic [3:0]  m;
    logic        l;
    logic [15:0] s;
    int          id;
  } exp_t;

  logic  hclk;
  logic  hrst;
  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    step_no = 0;

  ahb_arbiter_if bus();

  ahb_arbiter #(.NUM_MASTERS(16), .DEFAULT_MASTER(0)) dut (
    .hclk (hclk),
    .hrst (hrst),
    .bus  (bus)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic push_exp(input logic [15:0] eg, input logic [3:0] em,
                          input logic el, input logic [15:0] es);
    exp_t e;
    e.g = eg; e.m = em; e.l = el; e.s = es; e.id = step_no;
    q.push_back(e);
    step_no++;
  endtask

  // One bus cycle: drive at negedge, queue the expectation for the next edge.
  task automatic cyc(input logic rst, input logic [15:0] br, input logic [15:0] lk,
                     input logic [15:0] sp, input logic rdy, input logic [1:0] tr,
                     input logic [1:0] rs, input logic [15:0] eg, input logic [3:0] em,
                     input logic el, input logic [15:0] es);
    @(negedge hclk);
    hrst        = rst;
    bus.hbusreq = br;
    bus.hlock   = lk;
    bus.hsplit  = sp;
    bus.hready  = rdy;
    bus.htrans  = tr;
    bus.hresp   = rs;
    @(posedge hclk);
    push_exp(eg, em, el, es);
  endtask

  // Asynchronous reset in the middle of a cycle; checked immediately and at the edge.
  task automatic rst_pulse();
    @(negedge hclk);
    push_exp(16'h0001, 4'd0, 1'b0, 16'h0000);
    hrst = 1'b1;
    @(posedge hclk);
    push_exp(16'h0001, 4'd0, 1'b0, 16'h0000);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge hclk or posedge hrst);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (bus.hgrant !== e.g || bus.hmaster !== e.m ||
            bus.hmastlock !== e.l || bus.split_mask !== e.s) begin
          errors++;
          $display("FAIL step%0d: got hgrant=%h hmaster=%0d hmastlock=%b split_mask=%h, expected hgrant=%h hmaster=%0d hmastlock=%b split_mask=%h",
                   e.id, bus.hgrant, bus.hmaster, bus.hmastlock, bus.split_mask,
                   e.g, e.m, e.l, e.s);
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: run still active at time %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    hrst        = 1'b1;
    bus.hbusreq = '0;
    bus.hlock   = '0;
    bus.hsplit  = '0;
    bus.hready  = 1'b1;
    bus.htrans  = IDLE;
    bus.hresp   = OK;
    repeat (2) @(posedge hclk);

    // Reset and idle bus: default master owns everything.
    cyc(1, 16'h0000, 16'h0000, 16'h0000, 1, IDLE, OK, 16'h0001, 4'd0, 0, 16'h0000);
    repeat (3)
      cyc(0, 16'h0000, 16'h0000, 16'h0000, 1, IDLE, OK, 16'h0001, 4'd0, 0, 16'h0000);

    // Two requesters alternate; hmaster trails hgrant.
    cyc(0, 16'h0006, 0, 0, 1, NS, OK, 16'h0002, 4'd0, 0, 0);
    cyc(0, 16'h0006, 0, 0, 1, NS, OK, FX ? 16'h0002 : 16'h0004, 4'd1, 0, 0);
    cyc(0, 16'h0006, 0, 0, 1, NS, OK, 16'h0002, FX ? 4'd1 : 4'd2, 0, 0);
    cyc(0, 16'h0006, 0, 0, 1, NS, OK, FX ? 16'h0002 : 16'h0004, 4'd1, 0, 0);

    // Locked master 3 holds the bus, then releases to master 0.
    cyc(0, 16'h0008, 16'h0008, 0, 1, NS,   OK, 16'h0008, FX ? 4'd1 : 4'd2, 0, 0);
    cyc(0, 16'h0009, 16'h0008, 0, 1, NS,   OK, 16'h0008, 4'd3, 1, 0);
    cyc(0, 16'h0009, 16'h0008, 0, 1, SEQ,  OK, 16'h0008, 4'd3, 1, 0);
    cyc(0, 16'h0009, 16'h0000, 0, 1, IDLE, OK, 16'h0001, 4'd3, 0, 0);
    cyc(0, 16'h0000, 16'h0000, 0, 1, IDLE, OK, 16'h0001, 4'd0, 0, 0);

    // SPLIT of master 2 (two-cycle response), release by hsplit without hready.
    cyc(0, 16'h0004, 0, 16'h0000, 1, NS,   OK,  16'h0004, 4'd0, 0, 16'h0000);
    cyc(0, 16'h0004, 0, 16'h0000, 1, SEQ,  OK,  16'h0004, 4'd2, 0, 16'h0000);
    cyc(0, 16'h0004, 0, 16'h0000, 0, SEQ,  SPL, 16'h0004, 4'd2, 0, 16'h0000);
    cyc(0, 16'h0004, 0, 16'h0000, 1, SEQ,  SPL, 16'h0001, 4'd2, 0, 16'h0004);
    cyc(0, 16'h0004, 0, 16'h0000, 1, IDLE, OK,  16'h0001, 4'd0, 0, 16'h0004);
    cyc(0, 16'h0004, 0, 16'h0004, 0, IDLE, OK,  16'h0001, 4'd0, 0, 16'h0000);
    cyc(0, 16'h0004, 0, 16'h0000, 1, NS,   OK,  16'h0004, 4'd0, 0, 16'h0000);

    // Same-edge split set and release: set wins.
    cyc(0, 16'h0004, 0, 16'h0000, 1, SEQ,  OK,  16'h0004, 4'd2, 0, 16'h0000);
    cyc(0, 16'h0004, 0, 16'h0004, 1, SEQ,  SPL, 16'h0001, 4'd2, 0, 16'h0004);
    cyc(0, 16'h0004, 0, 16'h0004, 1, IDLE, OK,  16'h0001, 4'd0, 0, 16'h0000);
    cyc(0, 16'h0004, 0, 16'h0000, 1, NS,   OK,  16'h0004, 4'd0, 0, 16'h0000);

    // hready low: everything except split_mask freezes.
    cyc(0, 16'h0002, 0, 0, 0, NS, OK, 16'h0004, 4'd0, 0, 0);
    cyc(0, 16'h0002, 0, 0, 0, NS, OK, 16'h0004, 4'd0, 0, 0);
    cyc(0, 16'h0010, 0, 0, 0, NS, OK, 16'h0004, 4'd0, 0, 0);
    cyc(0, 16'h0010, 0, 0, 0, NS, OK, 16'h0004, 4'd0, 0, 0);
    cyc(0, 16'h0010, 0, 0, 1, NS, OK, 16'h0010, 4'd2, 0, 0);

    // Build split_mask=0x0030 (all-masked falls to default), then reset mid-burst.
    cyc(0, 16'h0010, 16'h0000, 0, 1, SEQ, OK,  16'h0010, 4'd4, 0, 16'h0000);
    cyc(0, 16'h0010, 16'h0000, 0, 1, SEQ, SPL, 16'h0001, 4'd4, 0, 16'h0010);
    cyc(0, 16'h0020, 16'h0000, 0, 1, NS,  OK,  16'h0020, 4'd0, 0, 16'h0010);
    cyc(0, 16'h0020, 16'h0000, 0, 1, SEQ, OK,  16'h0020, 4'd5, 0, 16'h0010);
    cyc(0, 16'h0020, 16'h0000, 0, 1, SEQ, SPL, 16'h0001, 4'd5, 0, 16'h0030);
    cyc(0, 16'h0032, 16'h0002, 0, 1, NS,  OK,  16'h0002, 4'd0, 0, 16'h0030);
    cyc(0, 16'h0032, 16'h0002, 0, 1, SEQ, OK,  16'h0002, 4'd1, 1, 16'h0030);
    rst_pulse();
    cyc(0, 16'h0000, 16'h0000, 0, 1, IDLE, OK, 16'h0001, 4'd0, 0, 16'h0000);

    // Round-robin pointer restarts at the default master after reset.
    cyc(0, 16'h0006, 16'h0000, 0, 1, NS,   OK,  16'h0002, 4'd0, 0, 0);
    // RETRY does not break a locked master's hold.
    cyc(0, 16'h0006, 16'h0002, 0, 1, SEQ,  RTY, 16'h0002, 4'd1, 1, 0);
    cyc(0, 16'h0004, 16'h0000, 0, 1, IDLE, OK,  16'h0004, 4'd1, 0, 0);

    repeat (2) @(negedge hclk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
